// File: rtl/ofs_asp_pkg.sv
// Shared ASP constants and types for the kernel CRA bridge.
// Optional access timeout is enabled by defining KERNEL_CRA_TIMEOUT_EN.
package ofs_asp_pkg;

    localparam int KERNEL_CRA_DATA_WIDTH       = 32;
    localparam int KERNEL_CRA_ADDR_WIDTH       = 8;
    localparam int KERNEL_CRA_BYTEENABLE_WIDTH = 4;
    localparam int KERNEL_CRA_NUM_CH           = 4;
    localparam int KERNEL_CRA_TIMEOUT_CYCLES   = 1024;

    localparam logic [31:0] KERNEL_CRA_TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RDW
    } cra_br_state_e;

endpackage

// File: rtl/kernel_cra_rst_sync.sv
// Kernel reset synchroniser: asserts asynchronously, releases after
// two clock edges so every kernel channel leaves reset together.
module kernel_cra_rst_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] r_sync;

    // Two-flop chain clocking a constant 1 through once reset lifts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], 1'b1};
    end

    assign o_rst_n = r_sync[1];

endmodule

// File: rtl/kernel_cra_multi_bridge.sv
// One host CRA agent fanned out to NUM_CH kernel CRA ports.
// Define KERNEL_CRA_TIMEOUT_EN to enable the access timeout.
module kernel_cra_multi_bridge
    import ofs_asp_pkg::*;
#(
    parameter int NUM_CH         = KERNEL_CRA_NUM_CH,
    parameter int CRA_DATA_WIDTH = KERNEL_CRA_DATA_WIDTH,
    parameter int CRA_ADDR_WIDTH = KERNEL_CRA_ADDR_WIDTH,
    parameter int CRA_BE_WIDTH   = KERNEL_CRA_BYTEENABLE_WIDTH,
    parameter int TIMEOUT_CYCLES = KERNEL_CRA_TIMEOUT_CYCLES,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [CRA_ADDR_WIDTH+CH_W-1:0]   h_address,
    input  logic                             h_read,
    input  logic                             h_write,
    input  logic [CRA_DATA_WIDTH-1:0]        h_writedata,
    input  logic [CRA_BE_WIDTH-1:0]          h_byteenable,
    output logic                             h_waitrequest,
    output logic [CRA_DATA_WIDTH-1:0]        h_readdata,
    output logic                             h_readdatavalid,
    output logic                             h_irq,
    output logic [NUM_CH*CRA_ADDR_WIDTH-1:0] k_address,
    output logic [NUM_CH-1:0]                k_read,
    output logic [NUM_CH-1:0]                k_write,
    output logic [NUM_CH*CRA_DATA_WIDTH-1:0] k_writedata,
    output logic [NUM_CH*CRA_BE_WIDTH-1:0]   k_byteenable,
    input  logic [NUM_CH-1:0]                k_waitrequest,
    input  logic [NUM_CH*CRA_DATA_WIDTH-1:0] k_readdata,
    input  logic [NUM_CH-1:0]                k_readdatavalid,
    input  logic [NUM_CH-1:0]                k_irq,
    output logic [NUM_CH-1:0]                k_reset_n,
    output logic                             timeout_err
);

    cra_br_state_e             r_state, w_state_n;
    logic [CH_W-1:0]           r_ch, w_ch_n;
    logic [CRA_ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic [CRA_DATA_WIDTH-1:0] r_wdata, w_wdata_n;
    logic [CRA_BE_WIDTH-1:0]   r_be, w_be_n;
    logic                      r_acc, w_acc_n;
    logic                      r_rdv, w_rdv_n;
    logic [CRA_DATA_WIDTH-1:0] r_rdata, w_rdata_n;
    logic [NUM_CH-1:0]         r_irq_q;

    logic [CH_W-1:0]           w_hch;
    logic                      w_hch_ok;
    logic                      w_kwait;
    logic                      w_kvalid;
    logic [CRA_DATA_WIDTH-1:0] w_kdata;
    logic                      w_k_rst_n;

    assign w_hch    = h_address[CRA_ADDR_WIDTH +: CH_W];
    assign w_hch_ok = 32'(w_hch) < 32'(NUM_CH);

`ifdef KERNEL_CRA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CRA_DATA_WIDTH-1:0] TMO_PAT =
        {(CRA_DATA_WIDTH/32){KERNEL_CRA_TIMEOUT_PATTERN}};

    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_n;
    logic          r_tmo_err, w_tmo_err_n;

    assign timeout_err = r_tmo_err;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign timeout_err  = 1'b0;
`endif

    // Pick the selected channel's kernel response signals
    always_comb begin
        w_kwait  = 1'b1;
        w_kvalid = 1'b0;
        w_kdata  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_kwait  = k_waitrequest[c];
                w_kvalid = k_readdatavalid[c];
                w_kdata  = k_readdata[c*CRA_DATA_WIDTH +: CRA_DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic of the access FSM
    always_comb begin
        w_state_n = r_state;
        w_ch_n    = r_ch;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_be_n    = r_be;
        w_acc_n   = 1'b0;
        w_rdv_n   = 1'b0;
        w_rdata_n = r_rdata;
`ifdef KERNEL_CRA_TIMEOUT_EN
        w_tmo_cnt_n = r_tmo_cnt;
        w_tmo_err_n = r_tmo_err;
`endif
        unique case (r_state)
            IDLE: begin
                if ((h_read || h_write) && !r_acc) begin
                    w_ch_n    = w_hch;
                    w_addr_n  = h_address[CRA_ADDR_WIDTH-1:0];
                    w_wdata_n = h_writedata;
                    w_be_n    = h_byteenable;
`ifdef KERNEL_CRA_TIMEOUT_EN
                    w_tmo_cnt_n = '0;
`endif
                    if (!w_hch_ok) begin
                        w_acc_n = 1'b1;
                        if (h_read) begin
                            w_rdv_n   = 1'b1;
                            w_rdata_n = '0;
                        end
                    end else if (h_read) begin
                        w_state_n = RD;
                    end else begin
                        w_state_n = WR;
                    end
                end
            end
            WR: begin
                if (!w_kwait) begin
                    w_acc_n   = 1'b1;
                    w_state_n = IDLE;
                end
            end
            RD: begin
                if (!w_kwait) w_state_n = RDW;
            end
            RDW: begin
                if (w_kvalid) begin
                    w_rdv_n   = 1'b1;
                    w_rdata_n = w_kdata;
                    w_acc_n   = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
`ifdef KERNEL_CRA_TIMEOUT_EN
        if (r_state != IDLE && w_state_n != IDLE) begin
            if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                w_acc_n     = 1'b1;
                w_tmo_err_n = 1'b1;
                w_state_n   = IDLE;
                if (r_state != WR) begin
                    w_rdv_n   = 1'b1;
                    w_rdata_n = TMO_PAT;
                end
            end else begin
                w_tmo_cnt_n = r_tmo_cnt + 1'b1;
            end
        end
`endif
    end

    // State and command registers; reset discards any in-flight access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_acc   <= 1'b0;
            r_rdv   <= 1'b0;
            r_rdata <= '0;
            r_irq_q <= '0;
`ifdef KERNEL_CRA_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_ch    <= w_ch_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_be    <= w_be_n;
            r_acc   <= w_acc_n;
            r_rdv   <= w_rdv_n;
            r_rdata <= w_rdata_n;
            r_irq_q <= k_irq;
`ifdef KERNEL_CRA_TIMEOUT_EN
            r_tmo_cnt <= w_tmo_cnt_n;
            r_tmo_err <= w_tmo_err_n;
`endif
        end
    end

    assign h_waitrequest   = ~r_acc;
    assign h_readdatavalid = r_rdv;
    assign h_readdata      = r_rdata;
    assign h_irq           = |r_irq_q;

    // Fields fan out to every slice; strobes only to the selected one
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign k_address[g*CRA_ADDR_WIDTH +: CRA_ADDR_WIDTH] = r_addr;
        assign k_writedata[g*CRA_DATA_WIDTH +: CRA_DATA_WIDTH] = r_wdata;
        assign k_byteenable[g*CRA_BE_WIDTH +: CRA_BE_WIDTH] = r_be;
        assign k_write[g] = (r_state == WR) && (r_ch == CH_W'(g));
        assign k_read[g]  = (r_state == RD) && (r_ch == CH_W'(g));
    end

    kernel_cra_rst_sync u_rst_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .o_rst_n (w_k_rst_n)
    );

    assign k_reset_n = {NUM_CH{w_k_rst_n}};

endmodule
